// File: rtl/dual_issue_ctrl.sv
// Dual-issue controller: pairs, splits or bubbles decoded instructions
// and registers the two lane bundles plus the extend-unit feed.
module dual_issue_ctrl #(
   parameter int DESC_W = 42,
   parameter int REG_W  = 4
) (
   input  logic              i_CLK,
   input  logic              i_RST,
   input  logic              i_Valid1,
   input  logic              i_Valid2,
   input  logic [DESC_W-1:0] i_Inst1,
   input  logic [DESC_W-1:0] i_Inst2,
   input  logic              i_ExStall,
   input  logic              i_Flush,
   output logic              o_Ready,
   output logic              o_IssV1,
   output logic              o_IssV2,
   output logic [DESC_W-1:0] o_Iss1,
   output logic [DESC_W-1:0] o_Iss2,
   output logic [1:0]        o_ImmSrc1D,
   output logic [1:0]        o_ImmSrc2D,
   output logic [23:0]       o_Extend24_1,
   output logic [23:0]       o_Extend24_2
);

   typedef enum logic {S_RUN, S_HOLD} state_t;

   function automatic logic [REG_W-1:0] f_rd(
      input logic [DESC_W-1:0] d);
      return d[36:33];
   endfunction

   function automatic logic f_reads(
      input logic [DESC_W-1:0] d,
      input logic [REG_W-1:0]  r);
      return (d[32:29] == r) | (d[24] & (d[28:25] == r));
   endfunction

   function automatic logic f_hits(
      input logic [DESC_W-1:0] d,
      input logic              v0,
      input logic [REG_W-1:0]  r0,
      input logic              v1,
      input logic [REG_W-1:0]  r1);
      return (v0 & f_reads(d, r0)) | (v1 & f_reads(d, r1));
   endfunction

   state_t              state_q, state_d;
   logic [DESC_W-1:0]   hold_q, hold_d;
   logic                issv1_q, issv1_d;
   logic                issv2_q, issv2_d;
   logic [DESC_W-1:0]   iss1_q, iss1_d;
   logic [DESC_W-1:0]   iss2_q, iss2_d;
   logic                ldv0_q, ldv0_d;
   logic                ldv1_q, ldv1_d;
   logic [REG_W-1:0]    ldrd0_q, ldrd0_d;
   logic [REG_W-1:0]    ldrd1_q, ldrd1_d;
   logic                bubble;
   logic                split;
   logic                issue;

   // Load-use hazard against the instructions that would issue next.
   always_comb begin
      bubble = 1'b0;
      if (state_q == S_HOLD) begin
         bubble = f_hits(hold_q, ldv0_q, ldrd0_q, ldv1_q, ldrd1_q);
      end else begin
         bubble = (i_Valid1 &
                   f_hits(i_Inst1, ldv0_q, ldrd0_q, ldv1_q, ldrd1_q)) |
                  (i_Valid2 &
                   f_hits(i_Inst2, ldv0_q, ldrd0_q, ldv1_q, ldrd1_q));
      end
   end

   // Pair must be split: branch, shared memory port, RAW or WAW.
   always_comb begin
      split = i_Inst1[41] |
              (i_Inst1[40] & i_Inst2[40]) |
              (i_Inst1[39] & f_reads(i_Inst2, f_rd(i_Inst1))) |
              (i_Inst1[39] & i_Inst2[39] &
               (f_rd(i_Inst1) == f_rd(i_Inst2)));
   end

   assign o_Ready = (state_q == S_RUN) & ~i_ExStall &
                    ~i_Flush & ~bubble;

   // Next state, lane bundles, hold register and load tracker.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      issv1_d = issv1_q;
      issv2_d = issv2_q;
      iss1_d  = iss1_q;
      iss2_d  = iss2_q;
      ldv0_d  = ldv0_q;
      ldv1_d  = ldv1_q;
      ldrd0_d = ldrd0_q;
      ldrd1_d = ldrd1_q;
      issue   = 1'b0;
      if (i_Flush) begin
         issv1_d = 1'b0;
         issv2_d = 1'b0;
         hold_d  = '0;
         state_d = S_RUN;
      end else if (!i_ExStall) begin
         if (bubble) begin
            issv1_d = 1'b0;
            issv2_d = 1'b0;
         end else if (state_q == S_HOLD) begin
            issue   = 1'b1;
            issv1_d = 1'b1;
            issv2_d = 1'b0;
            iss1_d  = hold_q;
            state_d = S_RUN;
         end else if (i_Valid1 && i_Valid2) begin
            issue   = 1'b1;
            issv1_d = 1'b1;
            iss1_d  = i_Inst1;
            if (split) begin
               issv2_d = 1'b0;
               hold_d  = i_Inst2;
               state_d = S_HOLD;
            end else begin
               issv2_d = 1'b1;
               iss2_d  = i_Inst2;
            end
         end else if (i_Valid1 || i_Valid2) begin
            issue   = 1'b1;
            issv1_d = 1'b1;
            issv2_d = 1'b0;
            iss1_d  = i_Valid1 ? i_Inst1 : i_Inst2;
         end else begin
            issv1_d = 1'b0;
            issv2_d = 1'b0;
         end
      end
      if (i_Flush || !i_ExStall) begin
         ldv0_d  = issue & issv1_d & iss1_d[40] & iss1_d[39];
         ldv1_d  = issue & issv2_d & iss2_d[40] & iss2_d[39];
         ldrd0_d = f_rd(iss1_d);
         ldrd1_d = f_rd(iss2_d);
      end
   end

   // State and lane registers.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_q <= S_RUN;
         hold_q  <= '0;
         issv1_q <= 1'b0;
         issv2_q <= 1'b0;
         iss1_q  <= '0;
         iss2_q  <= '0;
         ldv0_q  <= 1'b0;
         ldv1_q  <= 1'b0;
         ldrd0_q <= '0;
         ldrd1_q <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         issv1_q <= issv1_d;
         issv2_q <= issv2_d;
         iss1_q  <= iss1_d;
         iss2_q  <= iss2_d;
         ldv0_q  <= ldv0_d;
         ldv1_q  <= ldv1_d;
         ldrd0_q <= ldrd0_d;
         ldrd1_q <= ldrd1_d;
      end
   end

   assign o_IssV1      = issv1_q;
   assign o_IssV2      = issv2_q;
   assign o_Iss1       = iss1_q;
   assign o_Iss2       = iss2_q;
   assign o_ImmSrc1D   = issv1_q ? iss1_q[38:37] : 2'b11;
   assign o_ImmSrc2D   = issv2_q ? iss2_q[38:37] : 2'b11;
   assign o_Extend24_1 = issv1_q ? iss1_q[23:0] : 24'd0;
   assign o_Extend24_2 = issv2_q ? iss2_q[23:0] : 24'd0;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Scoreboard bench for dual_issue_ctrl: directed pairs push the
// expected lane bundles, a negedge monitor pops and compares.
module tb_dual_issue_ctrl;

   logic        clk;
   logic        i_RST;
   logic        i_Valid1, i_Valid2;
   logic [41:0] i_Inst1, i_Inst2;
   logic        i_ExStall, i_Flush;
   logic        o_Ready, o_IssV1, o_IssV2;
   logic [41:0] o_Iss1, o_Iss2;
   logic [1:0]  o_ImmSrc1D, o_ImmSrc2D;
   logic [23:0] o_Extend24_1, o_Extend24_2;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        v1;
      logic        v2;
      logic [41:0] d1;
      logic [41:0] d2;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   exp_t e0;

   logic        live_q  = 1'b0;
   logic        stall_q = 1'b0;
   logic        snap_v1, snap_v2;
   logic [41:0] snap_d1, snap_d2;

   dual_issue_ctrl #(.DESC_W(42), .REG_W(4)) dut (
      .i_CLK        (clk),
      .i_RST        (i_RST),
      .i_Valid1     (i_Valid1),
      .i_Valid2     (i_Valid2),
      .i_Inst1      (i_Inst1),
      .i_Inst2      (i_Inst2),
      .i_ExStall    (i_ExStall),
      .i_Flush      (i_Flush),
      .o_Ready      (o_Ready),
      .o_IssV1      (o_IssV1),
      .o_IssV2      (o_IssV2),
      .o_Iss1       (o_Iss1),
      .o_Iss2       (o_Iss2),
      .o_ImmSrc1D   (o_ImmSrc1D),
      .o_ImmSrc2D   (o_ImmSrc2D),
      .o_Extend24_1 (o_Extend24_1),
      .o_Extend24_2 (o_Extend24_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [41:0] mk(
      input logic        br,
      input logic        mem,
      input logic        rw,
      input logic [1:0]  is,
      input logic [3:0]  rd,
      input logic [3:0]  rn,
      input logic [3:0]  rm,
      input logic        um,
      input logic [23:0] imm);
      return {br, mem, rw, is, rd, rn, rm, um, imm};
   endfunction

   task automatic chk(
      input string       nm,
      input logic [63:0] act,
      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Classify each edge: normal issue edge, stalled edge, or reset.
   always @(posedge clk) begin
      live_q  <= !i_ExStall && !i_RST;
      stall_q <= i_ExStall && !i_RST;
   end

   // Monitor: compare registered lanes against the scoreboard.
   always @(negedge clk) begin
      if (live_q) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got v1=%b, no entry expected",
                     o_IssV1);
         end else begin
            mon_e = sb.pop_front();
            chk("issv1", o_IssV1, mon_e.v1);
            chk("issv2", o_IssV2, mon_e.v2);
            if (mon_e.v1) begin
               chk("iss1", o_Iss1, mon_e.d1);
               chk("imms1", o_ImmSrc1D, mon_e.d1[38:37]);
               chk("ext1", o_Extend24_1, mon_e.d1[23:0]);
            end else begin
               chk("imms1_idle", o_ImmSrc1D, 2'b11);
               chk("ext1_idle", o_Extend24_1, 24'd0);
            end
            if (mon_e.v2) begin
               chk("iss2", o_Iss2, mon_e.d2);
               chk("imms2", o_ImmSrc2D, mon_e.d2[38:37]);
               chk("ext2", o_Extend24_2, mon_e.d2[23:0]);
            end else begin
               chk("imms2_idle", o_ImmSrc2D, 2'b11);
               chk("ext2_idle", o_Extend24_2, 24'd0);
            end
         end
      end else if (stall_q) begin
         chk("frz_v1", o_IssV1, snap_v1);
         chk("frz_v2", o_IssV2, snap_v2);
         chk("frz_d1", o_Iss1, snap_d1);
         chk("frz_d2", o_Iss2, snap_d2);
      end
      snap_v1 = o_IssV1;
      snap_v2 = o_IssV2;
      snap_d1 = o_Iss1;
      snap_d2 = o_Iss2;
   end

   // One clock edge of stimulus; exp is what that edge must issue.
   task automatic step(
      input logic        v1,
      input logic        v2,
      input logic [41:0] a,
      input logic [41:0] b,
      input logic        st,
      input logic        fl,
      input logic        rdy,
      input exp_t        exp);
      @(negedge clk);
      i_Valid1  = v1;
      i_Valid2  = v2;
      i_Inst1   = a;
      i_Inst2   = b;
      i_ExStall = st;
      i_Flush   = fl;
      #1;
      chk("ready", o_Ready, rdy);
      if (!st) sb.push_back(exp);
   endtask

   task automatic idle_in();
      i_Valid1  = 1'b0;
      i_Valid2  = 1'b0;
      i_Inst1   = '0;
      i_Inst2   = '0;
      i_ExStall = 1'b0;
      i_Flush   = 1'b0;
   endtask

   task automatic chk_reset_outs();
      chk("rst_v1", o_IssV1, 1'b0);
      chk("rst_v2", o_IssV2, 1'b0);
      chk("rst_d1", o_Iss1, 42'd0);
      chk("rst_imms1", o_ImmSrc1D, 2'b11);
      chk("rst_imms2", o_ImmSrc2D, 2'b11);
      chk("rst_ext1", o_Extend24_1, 24'd0);
      chk("rst_ext2", o_Extend24_2, 24'd0);
   endtask

   logic [41:0] a1, a2, b1, b2, ld, u1, l2, x1, x2;
   logic [41:0] l3, y, st_i, ld2, w1, w2, br, ad;

   initial begin
      e0 = '0;
      a1   = mk(0, 0, 1, 2'b00, 1, 7, 8, 0, 24'h0000FF);
      a2   = mk(0, 0, 1, 2'b00, 6, 2, 3, 1, 24'h000012);
      b1   = mk(0, 0, 1, 2'b00, 4, 1, 0, 0, 24'h000010);
      b2   = mk(0, 0, 1, 2'b01, 9, 4, 0, 0, 24'h000022);
      ld   = mk(0, 1, 1, 2'b01, 5, 2, 0, 0, 24'h000040);
      u1   = mk(0, 0, 1, 2'b00, 6, 5, 0, 0, 24'h000033);
      l2   = mk(0, 1, 1, 2'b00, 3, 2, 0, 0, 24'h000044);
      x1   = mk(0, 0, 1, 2'b00, 10, 11, 0, 0, 24'h000055);
      x2   = mk(0, 0, 1, 2'b00, 13, 12, 3, 1, 24'h000066);
      l3   = mk(0, 1, 1, 2'b01, 3, 2, 0, 0, 24'h000077);
      y    = mk(0, 0, 1, 2'b00, 14, 1, 3, 0, 24'h000088);
      st_i = mk(0, 1, 0, 2'b01, 7, 2, 0, 0, 24'h000004);
      ld2  = mk(0, 1, 1, 2'b01, 8, 2, 0, 0, 24'h000008);
      w1   = mk(0, 0, 1, 2'b00, 9, 1, 2, 1, 24'h000099);
      w2   = mk(0, 0, 1, 2'b00, 9, 3, 4, 1, 24'h0000AA);
      br   = mk(1, 0, 0, 2'b10, 0, 0, 0, 0, 24'h800000);
      ad   = mk(0, 0, 1, 2'b00, 2, 3, 1, 1, 24'h0000BB);

      i_RST = 1'b1;
      idle_in();
      repeat (2) @(negedge clk);
      #1;
      chk_reset_outs();
      #1;
      i_RST = 1'b0;
      sb.push_back(e0);

      // Independent pair dual-issues
      step(1, 1, a1, a2, 0, 0, 1, '{1, 1, a1, a2});
      // RAW split, then held issues, then ready again
      step(1, 1, b1, b2, 0, 0, 1, '{1, 0, b1, 0});
      step(0, 0, 0, 0, 0, 0, 0, '{1, 0, b2, 0});
      step(0, 0, 0, 0, 0, 0, 1, e0);
      // Load-use via Rn: one bubble then issue
      step(1, 0, ld, 0, 0, 0, 1, '{1, 0, ld, 0});
      step(1, 0, u1, 0, 0, 0, 0, e0);
      step(1, 0, u1, 0, 0, 0, 1, '{1, 0, u1, 0});
      // Load-use via Rm with UsesRm in slot 2
      step(1, 0, l2, 0, 0, 0, 1, '{1, 0, l2, 0});
      step(1, 1, x1, x2, 0, 0, 0, e0);
      step(1, 1, x1, x2, 0, 0, 1, '{1, 1, x1, x2});
      // Rm match without UsesRm is not a hazard
      step(1, 0, l3, 0, 0, 0, 1, '{1, 0, l3, 0});
      step(1, 0, y, 0, 0, 0, 1, '{1, 0, y, 0});
      // Two memory ops split
      step(1, 1, st_i, ld2, 0, 0, 1, '{1, 0, st_i, 0});
      step(0, 0, 0, 0, 0, 0, 0, '{1, 0, ld2, 0});
      step(0, 0, 0, 0, 0, 0, 1, e0);
      // WAW split
      step(1, 1, w1, w2, 0, 0, 1, '{1, 0, w1, 0});
      step(0, 0, 0, 0, 0, 0, 0, '{1, 0, w2, 0});
      // Only slot 2 valid issues in lane 1
      step(0, 1, 0, a2, 0, 0, 1, '{1, 0, a2, 0});
      // Branch split, flush kills the held ADD
      step(1, 1, br, ad, 0, 0, 1, '{1, 0, br, 0});
      step(0, 0, 0, 0, 0, 1, 0, e0);
      step(0, 0, 0, 0, 0, 0, 1, e0);
      // Flush in RUN drops the presented pair
      step(1, 1, a1, a2, 0, 1, 0, e0);
      // Stall in RUN: pair not taken until released
      step(1, 1, a1, a2, 1, 0, 0, e0);
      step(1, 1, a1, a2, 0, 0, 1, '{1, 1, a1, a2});
      // Stall three cycles mid-HOLD
      step(1, 1, b1, b2, 0, 0, 1, '{1, 0, b1, 0});
      repeat (3) step(0, 0, 0, 0, 1, 0, 0, e0);
      step(0, 0, 0, 0, 0, 0, 0, '{1, 0, b2, 0});
      step(0, 0, 0, 0, 0, 0, 1, e0);
      // Async reset mid-HOLD loses the held instruction
      step(1, 1, b1, b2, 0, 0, 1, '{1, 0, b1, 0});
      @(negedge clk);
      #2;
      idle_in();
      i_RST = 1'b1;
      #1;
      chk_reset_outs();
      @(negedge clk);
      #2;
      i_RST = 1'b0;
      sb.push_back(e0);
      step(0, 0, 0, 0, 0, 0, 1, e0);
      step(1, 1, a1, a2, 0, 0, 1, '{1, 1, a1, a2});
      step(0, 0, 0, 0, 0, 0, 1, e0);
      @(negedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/dual_issue_ctrl.md
Name: dual_issue_ctrl

Overview:
- Issue controller for the two-lane datapath. It sits between decode and the per-lane immediate extend / execute stage.
- Each cycle it takes one decoded instruction pair, with slot 1 older than slot 2.
- It decides whether to issue both together, split them across two cycles, or insert a load-use bubble.
- It drives the registered lane bundles, including the per-lane ImmSrc and 24-bit immediate fields that feed the extend unit.

Parameters:
- DESC_W, 42, width of the packed instruction descriptor. Fields MSB→LSB: Branch[41], Mem[40], RegWr[39], ImmSrc[38:37], Rd[36:33], Rn[32:29], Rm[28:25], UsesRm[24], Imm24[23:0].
- REG_W, 4, register index width.

Ports:
- i_CLK  in  1  clock
- i_RST  in  1  asynchronous active-high reset
- i_Valid1  in  1  slot 1 (older) descriptor valid
- i_Valid2  in  1  slot 2 (younger) descriptor valid
- i_Inst1  in  DESC_W  slot 1 descriptor
- i_Inst2  in  DESC_W  slot 2 descriptor
- i_ExStall  in  1  execute not ready; hold all state and outputs
- i_Flush  in  1  taken branch resolved; kill everything in flight
- o_Ready  out  1  input pair accepted at this edge (combinational)
- o_IssV1  out  1  lane 1 issue valid (registered)
- o_IssV2  out  1  lane 2 issue valid (registered)
- o_Iss1  out  DESC_W  lane 1 descriptor (registered)
- o_Iss2  out  DESC_W  lane 2 descriptor (registered)
- o_ImmSrc1D  out  2  lane 1 extend select (to extend unit)
- o_ImmSrc2D  out  2  lane 2 extend select (to extend unit)
- o_Extend24_1  out  24  lane 1 immediate field (to extend unit)
- o_Extend24_2  out  24  lane 2 immediate field (to extend unit)

Behaviour:
- Clock and reset: single clock i_CLK; i_RST asynchronous, active-high.
- Reset values: state RUN; hold register empty; load tracker cleared; o_IssV1/2=0; o_Iss1/2=0; o_ImmSrc1D/2D=2'b11; o_Extend24_1/2=0.
- States:
  - RUN: accepting pairs.
  - HOLD: younger instruction of a split pair is held.
- o_Ready = (state==RUN) & !i_ExStall & !i_Flush & !bubble.
- A pair is consumed at a posedge when o_Ready is 1, regardless of the valid bits.
- Priority, highest first: i_Flush > i_ExStall > load-use bubble > HOLD issue > RUN issue.
- Flush:
  - Next edge: o_IssV1/2=0, hold cleared, load tracker cleared, state→RUN.
  - The pair presented during the flush is dropped.
- ExStall: every register holds its value; nothing is accepted.
- Split condition (i_Valid1 & i_Valid2 in RUN), any of:
  - Inst1.Branch.
  - Both Mem (one shared memory port).
  - RAW: Inst1.RegWr and (Inst2.Rn==Inst1.Rd, or Inst2.UsesRm and Inst2.Rm==Inst1.Rd).
  - WAW: both RegWr and same Rd.
- On split: Inst1 issues alone in lane 1, Inst2 goes to the hold register, state→HOLD.
  - If Inst1.Branch, the held instruction is still issued next cycle unless i_Flush arrives first.
- HOLD: the held instruction issues alone in lane 1 with o_IssV2=0; state→RUN; o_Ready=0 throughout HOLD.
- No split, both valid: dual issue, Inst1→lane 1, Inst2→lane 2.
- Single valid slot (either one): issues in lane 1.
- Lane 2 is never valid while lane 1 is invalid.
- Load-use tracker:
  - On every issuing edge, record for each issued lane with Mem & RegWr: its Rd plus a valid bit.
  - On non-issuing edges, clear the tracker.
- Bubble:
  - Asserted when any candidate (HOLD: the held instruction; RUN: valid slots) reads a tracked Rd via Rn, or via Rm with UsesRm.
  - Effect: next edge o_IssV1/2=0, tracker cleared, state unchanged.
  - Bubble lasts exactly one cycle.
- Extend feed, derived from the registered lanes:
  - o_ImmSrcND = o_IssVN ? o_IssN.ImmSrc : 2'b11.
  - o_Extend24_N = o_IssVN ? o_IssN.Imm24 : 0.
- Reset mid-split: the held instruction is lost and state→RUN.

Test Plan:
- Independent ALU pair: Inst1 Rd=1, Inst2 Rn=2 Rm=3, ImmSrc 00/00, Imm 0x0000FF/0x000012 → o_Ready=1; next cycle IssV1=IssV2=1; o_Extend24_1=0x0000FF, o_Extend24_2=0x000012.
- RAW split: Inst1 RegWr Rd=4; Inst2 Rn=4 → cycle 1: IssV1=1, IssV2=0, o_Ready=0 in HOLD; cycle 2: lane 1 = Inst2, IssV2=0; cycle 3: o_Ready=1.
- Load-use: issue LDR (Mem, RegWr, Rd=5, ImmSrc=01); next pair reads Rn=5 → one cycle with IssV1=IssV2=0 and o_Ready=0, then issues; ImmSrc1D=01 visible on the LDR's issue cycle.
- Double memory: STR+LDR pair → split across two cycles; no lane ever carries both Mem ops.
- Branch + flush: Inst1 Branch with Imm24=0x800000, Inst2 ADD → Inst1 issues with ImmSrc1D=10; i_Flush in HOLD → held ADD never issues, state RUN, o_IssV1/2=0.
- ExStall and reset: assert i_ExStall for 3 cycles mid-HOLD → outputs frozen, issue resumes unchanged after release; async i_RST mid-HOLD → immediate clear, ImmSrc1D/2D=11.
